weighted_rr_arbiter: RTL and testbench

//  N-requester arbiter with registered one-hot grant. Successor to the plain round-robin arbiter.

---
 rtl/arb_pkg.sv | 29 ++
 rtl/weighted_rr_arbiter_rr_pick.sv | 40 ++++
 rtl/weighted_rr_arbiter.sv | 103 ++++++++++
 tb/tb_weighted_rr_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter family: mode encodings, a constant clog2
// and a one-hot builder wide enough for any supported requester count.
package arb_pkg;

  localparam logic ARB_MODE_RR  = 1'b0;
  localparam logic ARB_MODE_WRR = 1'b1;

  // Upper bound on N for the shared one-hot helper; callers slice the low N bits.
  localparam int ARB_MAX_N = 256;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

  function automatic logic [ARB_MAX_N-1:0] onehot(input int idx, input int n);
    logic [ARB_MAX_N-1:0] v;
    v = '0;
    if ((idx >= 0) && (idx < n) && (idx < ARB_MAX_N)) begin
      v[idx] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/weighted_rr_arbiter_rr_pick.sv
// Rotating-priority search: first set req bit at or after start, wrapping modulo N.
// Duplicating the request vector turns the wrap into a plain priority encode.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N    = 32,
  parameter int IDXW = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] start,
  output logic            found,
  output logic [IDXW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] masked;

  always_comb begin
    dbl  = {req, req};
    mask = '0;
    for (int k = 0; k < 2*N; k++) begin
      mask[k] = (k >= int'(start));
    end
    masked = dbl & mask;
  end

  // Scan from the top so the lowest surviving bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 2*N-1; k >= 0; k--) begin
      if (masked[k]) begin
        found = 1'b1;
        idx   = (k >= N) ? IDXW'(k - N) : IDXW'(k);
      end
    end
  end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// N-way arbiter with registered one-hot grant, optional per-requester weights
// (consecutive-cycle credits) and per-requester lock for multi-beat transfers.
module weighted_rr_arbiter
  import arb_pkg::*;
#(
  parameter  int N    = 32,
  parameter  int WW   = 4,
  localparam int IDXW = clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    lock,
  input  logic [N*WW-1:0] weight,
  input  logic            mode,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid
);

  localparam logic [WW-1:0] CREDIT_ONE = WW'(1);

  logic [N-1:0]    gnt_q, gnt_d;
  logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [WW-1:0]   credit_q, credit_d;

  logic [IDXW-1:0]      search_start;
  logic                 pick_found;
  logic [IDXW-1:0]      pick_idx;
  logic [WW-1:0]        pick_weight;
  logic [WW-1:0]        pick_credit;
  logic [ARB_MAX_N-1:0] pick_onehot;
  logic                 hold_lock;
  logic                 hold_weight;

  assign search_start = (ptr_q == IDXW'(N-1)) ? '0 : ptr_q + 1'b1;

  rr_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
    .req   (req),
    .start (search_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Weight of the candidate winner; zero is promoted to a single-cycle turn.
  always_comb begin
    pick_weight = weight[int'(pick_idx)*WW +: WW];
    pick_credit = (pick_weight == '0) ? CREDIT_ONE : pick_weight;
    pick_onehot = onehot(int'(pick_idx), N);
  end

  assign hold_lock   = gnt_valid_q && req[ptr_q] && lock[ptr_q];
  assign hold_weight = (mode == ARB_MODE_WRR) && gnt_valid_q && req[ptr_q] &&
                       (credit_q > CREDIT_ONE);

  always_comb begin
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;
    credit_d    = credit_q;
    if (hold_lock) begin
      // Locked beats are free: credit is left for after the lock releases.
    end else if (hold_weight) begin
      credit_d = credit_q - CREDIT_ONE;
    end else if (pick_found) begin
      gnt_d       = pick_onehot[N-1:0];
      gnt_idx_d   = pick_idx;
      gnt_valid_d = 1'b1;
      ptr_d       = pick_idx;
      credit_d    = (mode == ARB_MODE_WRR) ? pick_credit : CREDIT_ONE;
    end else begin
      gnt_d       = '0;
      gnt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= IDXW'(N-1);
      credit_q    <= '0;
    end else begin
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
      credit_q    <= credit_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Directed and random checks for weighted_rr_arbiter with hand-computed expectations.
module tb_weighted_rr_arbiter;

  localparam int N     = 32;
  localparam int WW    = 4;
  localparam int IDXW  = 5;
  localparam int BOUND = (N-1)*15 + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    lock;
  logic [N*WW-1:0] weight;
  logic            mode;
  logic [N-1:0]    gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  weighted_rr_arbiter #(.N(N), .WW(WW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .weight    (weight),
    .mode      (mode),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic [31:0] exp_gnt, input int exp_idx);
    chk({tag, "_gnt"}, gnt, exp_gnt);
    chk({tag, "_idx"}, 32'(gnt_idx), 32'(exp_idx));
    chk({tag, "_valid"}, 32'(gnt_valid), 32'(exp_gnt != 0));
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("inv_valid", 32'(gnt_valid), 32'(|gnt));
      if (gnt_valid) chk("inv_idx", 32'(gnt[gnt_idx]), 32'd1);
    end
  end

  int unsigned wait_c [N];
  bit          pend   [N];
  int          maxw;
  int          grants;

  initial begin
    // T1 reset
    rst = 1'b1; req = $urandom; lock = '0; weight = '0; mode = 1'b0;
    #1;
    chk_gnt("t1_rst_async", 32'h0, 0);
    tick(); tick();
    chk_gnt("t1_rst_held", 32'h0, 0);
    @(negedge clk); rst = 1'b0; req = '0;
    tick();
    chk_gnt("t1_idle", 32'h0, 0);

    // T2 plain round robin
    req = 32'hF;
    tick(); chk_gnt("t2_a", 32'h1, 0);
    tick(); chk_gnt("t2_b", 32'h2, 1);
    tick(); chk_gnt("t2_c", 32'h4, 2);
    tick(); chk_gnt("t2_d", 32'h8, 3);
    tick(); chk_gnt("t2_e", 32'h1, 0);

    // T3 wrap-around and sole requester
    req = 32'h8000_0000;
    tick(); chk_gnt("t3_top", 32'h8000_0000, 31);
    req = 32'h1;
    tick(); chk_gnt("t3_wrap", 32'h1, 0);
    req = 32'h20;
    tick(); chk_gnt("t3_sole_a", 32'h20, 5);
    tick(); chk_gnt("t3_sole_b", 32'h20, 5);
    tick(); chk_gnt("t3_sole_c", 32'h20, 5);
    req = '0;
    tick(); chk_gnt("t3_idle_hold_idx", 32'h0, 5);

    // T4 weighted: w0=3, w1=1, w2=0 (acts as 1)
    mode = 1'b1;
    weight[0*WW +: WW] = 4'd3;
    weight[1*WW +: WW] = 4'd1;
    weight[2*WW +: WW] = 4'd0;
    req = 32'h7;
    tick(); chk_gnt("t4_0", 32'h1, 0);
    tick(); chk_gnt("t4_1", 32'h1, 0);
    tick(); chk_gnt("t4_2", 32'h1, 0);
    tick(); chk_gnt("t4_3", 32'h2, 1);
    tick(); chk_gnt("t4_4", 32'h4, 2);
    tick(); chk_gnt("t4_5", 32'h1, 0);
    tick(); chk_gnt("t4_6", 32'h1, 0);
    tick(); chk_gnt("t4_7", 32'h1, 0);
    tick(); chk_gnt("t4_8", 32'h2, 1);
    tick(); chk_gnt("t4_9", 32'h4, 2);

    // T5 lock in plain mode
    mode = 1'b0; req = 32'h3; lock = 32'h1;
    tick(); chk_gnt("t5_lock_1", 32'h1, 0);
    tick(); chk_gnt("t5_lock_2", 32'h1, 0);
    tick(); chk_gnt("t5_lock_3", 32'h1, 0);
    tick(); chk_gnt("t5_lock_4", 32'h1, 0);
    tick(); chk_gnt("t5_lock_5", 32'h1, 0);
    lock = '0;
    tick(); chk_gnt("t5_unlock", 32'h2, 1);

    // T5 lock does not consume credit: w0=2
    mode = 1'b1; weight[0*WW +: WW] = 4'd2;
    tick(); chk_gnt("t5w_arb", 32'h1, 0);
    lock = 32'h1;
    tick(); chk_gnt("t5w_lock_1", 32'h1, 0);
    tick(); chk_gnt("t5w_lock_2", 32'h1, 0);
    tick(); chk_gnt("t5w_lock_3", 32'h1, 0);
    lock = '0;
    tick(); chk_gnt("t5w_credit", 32'h1, 0);
    tick(); chk_gnt("t5w_next", 32'h2, 1);

    // T6 reset mid-turn
    weight[0*WW +: WW] = 4'd4;
    req = 32'h1;
    tick(); chk_gnt("t6_turn_1", 32'h1, 0);
    tick(); chk_gnt("t6_turn_2", 32'h1, 0);
    #2 rst = 1'b1;
    #1 chk_gnt("t6_rst_async", 32'h0, 0);
    @(negedge clk); rst = 1'b0; req = 32'h9;
    tick(); chk_gnt("t6_after", 32'h1, 0);

    // Random traffic against the starvation bound (no lock)
    lock = '0; maxw = 0; grants = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; wait_c[i] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 3) == 0)) begin
          pend[i] = 1'b1; wait_c[i] = 0;
        end
        req[i] = pend[i];
        weight[i*WW +: WW] = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 31) == 0) mode = ~mode;
      tick();
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          if (gnt[i]) begin
            grants++;
            pend[i] = ($urandom_range(0, 1) == 0);
            wait_c[i] = 0;
          end else begin
            wait_c[i]++;
            if (int'(wait_c[i]) > maxw) maxw = int'(wait_c[i]);
          end
        end
      end
    end
    chk("rand_starvation", 32'(maxw + 1 <= BOUND), 32'd1);
    chk("rand_some_grants", 32'(grants > 5000), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
